// File: rtl/dm_port_arbiter.sv
// Two-port round-robin arbiter in front of the single-port data RAM.
// Port 0 is the core load/store path and port 1 is the debug/loader path.
// Winner commands are registered onto the RAM pins one cycle after the grant.
// Read data is steered back to the issuing port by a tag pipeline that tracks RAM latency.
module dm_port_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,

    // Port 0: core load/store
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] ad0,
    input  logic [DATA_W-1:0] d0,
    output logic              gnt0,
    output logic              rvalid0,
    output logic [DATA_W-1:0] q0,
    output logic              stall0,

    // Port 1: debug / loader
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] ad1,
    input  logic [DATA_W-1:0] d1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] q1,

    // RAM side
    output logic              dm_we,
    output logic              dm_re,
    output logic [ADDR_W-1:0] dm_ad,
    output logic [DATA_W-1:0] dm_d,
    input  logic [DATA_W-1:0] dm_q
);

    // rr_last_q holds the most recently granted port; 1 at reset so port 0 wins first.
    logic              rr_last_q, rr_last_d;

    // Selected command for the cycle's winner
    logic              cmd_valid;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_ad;
    logic [DATA_W-1:0] sel_d;

    // Command currently presented on the RAM pins
    logic              dm_we_q, dm_re_q;
    logic [ADDR_W-1:0] dm_ad_q;
    logic [DATA_W-1:0] dm_d_q;
    logic              cmd_port_q;

    // Read-tag pipeline; the last stage lines up with valid dm_q
    logic [RD_LAT-1:0] tag_valid_q, tag_valid_d;
    logic [RD_LAT-1:0] tag_port_q, tag_port_d;
    logic              tag_exit_valid;
    logic              tag_exit_port;

    // Arbitration: a single requester always wins, contention goes to the port not served last.
    // Grants are suppressed while reset is asserted.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (rst) begin
            if (req0 && req1) begin
                gnt0 = rr_last_q;
                gnt1 = ~rr_last_q;
            end else begin
                gnt0 = req0;
                gnt1 = req1;
            end
        end
    end

    // Core stall: port 0 is waiting on the RAM this cycle
    always_comb begin
        stall0 = req0 & ~gnt0;
    end

    // Round-robin pointer update and winner command mux
    always_comb begin
        rr_last_d = rr_last_q;
        if (gnt1) begin
            rr_last_d = 1'b1;
        end else if (gnt0) begin
            rr_last_d = 1'b0;
        end

        cmd_valid = gnt0 | gnt1;
        sel_we    = gnt1 ? we1 : we0;
        sel_ad    = gnt1 ? ad1 : ad0;
        sel_d     = gnt1 ? d1  : d0;
    end

    // Arbitration state and RAM pin registers; address/data hold when idle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_q  <= 1'b1;
            dm_we_q    <= 1'b0;
            dm_re_q    <= 1'b0;
            dm_ad_q    <= '0;
            dm_d_q     <= '0;
            cmd_port_q <= 1'b0;
        end else begin
            rr_last_q  <= rr_last_d;
            dm_we_q    <= cmd_valid & sel_we;
            dm_re_q    <= cmd_valid & ~sel_we;
            if (cmd_valid) begin
                dm_ad_q    <= sel_ad;
                dm_d_q     <= sel_d;
                cmd_port_q <= gnt1;
            end
        end
    end

    // RAM pins are driven straight from registers
    always_comb begin
        dm_we = dm_we_q;
        dm_re = dm_re_q;
        dm_ad = dm_ad_q;
        dm_d  = dm_d_q;
    end

    // Tag shift: a read on the pins enters stage 0 and exits RD_LAT cycles later
    always_comb begin
        tag_valid_d    = tag_valid_q;
        tag_port_d     = tag_port_q;
        tag_valid_d[0] = dm_re_q;
        tag_port_d[0]  = cmd_port_q;
        for (int i = 1; i < int'(RD_LAT); i++) begin
            tag_valid_d[i] = tag_valid_q[i-1];
            tag_port_d[i]  = tag_port_q[i-1];
        end
    end

    // Tag pipeline register; reset drops any in-flight reads
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_valid_q <= '0;
            tag_port_q  <= '0;
        end else begin
            tag_valid_q <= tag_valid_d;
            tag_port_q  <= tag_port_d;
        end
    end

    // Response routing: dm_q passes through to the owning port only, others see zero
    always_comb begin
        tag_exit_valid = tag_valid_q[RD_LAT-1];
        tag_exit_port  = tag_port_q[RD_LAT-1];
        rvalid0        = tag_exit_valid & ~tag_exit_port;
        rvalid1        = tag_exit_valid & tag_exit_port;
        q0             = rvalid0 ? dm_q : '0;
        q1             = rvalid1 ? dm_q : '0;
    end

endmodule
